// File: rtl/pairing_result_unloader.sv
// Streams a captured Tate pairing result out as 32-bit words, least-significant first.
// Define UNLOAD_CHECKSUM_EN to append an XOR checksum word to every frame.
`ifndef W6
`define W6 1163
`endif

module pairing_result_unloader (
   input  logic          clk,
   input  logic          reset,
   input  logic          pair_done,
   input  logic [`W6:0]  pair_out,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [31:0]   out_data,
   output logic          out_last,
   output logic          busy
);

   localparam int DW = `W6 + 1;
   localparam int N  = (DW + 31) / 32;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef UNLOAD_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
   logic [31:0] csum_reg;
`else
   typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

   state_t          state_reg;
   logic            done_reg;
   logic [IW-1:0]   cnt_reg;
   logic [N*32-1:0] frame_reg;
   logic [N*32-1:0] pad_in;
   logic [31:0]     words [N];
   logic            capture;

   // Zero-extend so the top word carries zeros above the result width.
   assign pad_in  = (N*32)'(pair_out);
   assign capture = pair_done && !done_reg;

   for (genvar gi = 0; gi < N; gi++) begin : g_words
      assign words[gi] = frame_reg[32*gi +: 32];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         done_reg  <= 1'b0;
         cnt_reg   <= '0;
         frame_reg <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
         csum_reg  <= '0;
`endif
      end else begin
         done_reg <= pair_done;
         case (state_reg)
            IDLE: begin
               if (capture) begin
                  frame_reg <= pad_in;
                  cnt_reg   <= '0;
                  out_data  <= pad_in[31:0];
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
                  state_reg <= SEND;
`ifdef UNLOAD_CHECKSUM_EN
                  csum_reg  <= '0;
`endif
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (cnt_reg == IW'(N - 1)) begin
                     cnt_reg <= '0;
`ifdef UNLOAD_CHECKSUM_EN
                     out_data  <= csum_reg ^ out_data;
                     out_last  <= 1'b1;
                     state_reg <= CSUM;
`else
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     state_reg <= IDLE;
`endif
                  end else begin
                     cnt_reg  <= cnt_reg + IW'(1);
                     out_data <= words[cnt_reg + IW'(1)];
`ifdef UNLOAD_CHECKSUM_EN
                     csum_reg <= csum_reg ^ out_data;
                     out_last <= 1'b0;
`else
                     out_last <= (cnt_reg + IW'(1) == IW'(N - 1));
`endif
                  end
               end
            end
`ifdef UNLOAD_CHECKSUM_EN
            CSUM: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
